// File: rtl/keypad_pkg.sv
// Shared types and default timing for the keypad scanner.
package keypad_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    DWELL  = 1'b1
  } state_t;

  typedef logic [3:0] key_code_t;

  localparam int unsigned DEF_SETTLE_CYCLES = 4;
  localparam int unsigned DEF_DWELL_CYCLES  = 8;
  localparam int unsigned DEF_FIFO_DEPTH    = 4;

endpackage

// File: rtl/key_fifo.sv
// Key-code queue; a push while full is accepted only if a pop happens in the same cycle.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  key_code_t din,
  output key_code_t dout,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  key_code_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with held-key suppression and a key-code queue.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned DWELL_CYCLES  = DEF_DWELL_CYCLES,
  parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] buttonMux,
  input  logic [3:0] row,
  output logic [3:0] column,
  output logic       en,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       overflow
);

  localparam int unsigned MAX_CYC = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       col_idx;
  logic [15:0]      held;
  logic [15:0]      held_next;
  logic [3:0]       row_s1;
  logic [3:0]       row_s;

  logic [3:0]       held_col;
  logic [3:0]       elig;
  logic             accept;
  logic [1:0]       acc_row;
  logic             last_dwell;
  logic             pop;
  logic             push;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  key_code_t        push_code;

  assign held_col   = held[{col_idx, 2'b00} +: 4];
  assign last_dwell = (state == DWELL) && (cnt == CNT_W'(DWELL_CYCLES - 1));
  assign pop        = key_valid && key_ready;
  assign push       = accept && (!fifo_full || pop);
  assign drop       = accept && fifo_full && !pop;
  assign push_code  = {col_idx, acc_row};
  assign key_valid  = !fifo_empty;

  // Lowest eligible row wins; the rest of the same cycle's pulses are discarded.
  always_comb begin
    elig    = buttonMux & ~held_col;
    accept  = 1'b0;
    acc_row = '0;
    if (state == DWELL) begin
      for (int r = 3; r >= 0; r--) begin
        if (elig[r]) begin
          accept  = 1'b1;
          acc_row = 2'(r);
        end
      end
    end
  end

  // Release uses the synchronized rows; a same-cycle acceptance takes precedence.
  always_comb begin
    held_next = held;
    if (last_dwell) begin
      for (int r = 0; r < 4; r++) begin
        if (!row_s[r]) held_next[{col_idx, 2'(r)}] = 1'b0;
      end
    end
    if (push) held_next[push_code] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SETTLE;
      cnt      <= '0;
      col_idx  <= '0;
      column   <= 4'b0001;
      en       <= 1'b0;
      held     <= '0;
      row_s1   <= '0;
      row_s    <= '0;
      overflow <= 1'b0;
    end else begin
      row_s1 <= row;
      row_s  <= row_s1;
      held   <= held_next;
      if (drop) overflow <= 1'b1;
      case (state)
        SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            state <= DWELL;
            cnt   <= '0;
            en    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DWELL: begin
          if (last_dwell) begin
            state   <= SETTLE;
            cnt     <= '0;
            en      <= 1'b0;
            col_idx <= col_idx + 2'd1;
            column  <= {column[2:0], column[3]};
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= SETTLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  key_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (push_code),
    .dout (key_code),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule
